// File: rtl/t_lut_sweep_ctrl.sv
// Temporal-LUT sweep controller: round-robin arbitration of one shared sweep counter,
// unary pulse generation per granted request, and a tagged response handshake.
`ifndef INPUT_WIDTH
`define INPUT_WIDTH 8
`endif

module t_lut_sweep_ctrl #(
  parameter int INPUT_WIDTH = `INPUT_WIDTH,
  parameter int NUM_REQ     = 4,
  parameter int ID_W        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*INPUT_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [INPUT_WIDTH-1:0]         cnt_val,
  output logic                           cnt_en,
  input  logic                           abort,
  output logic                           pulse_out,
  output logic                           busy,
  output logic                           rsp_valid,
  output logic [ID_W-1:0]                rsp_id,
  input  logic                           rsp_ready,
  output logic                           sync_err
);

  typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, RESP} state_e;

  localparam logic [INPUT_WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [ID_W-1:0]        LAST_IDX = ID_W'(NUM_REQ - 1);

  state_e                 state_q, state_d;
  logic [ID_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]        id_q, id_d;
  logic [INPUT_WIDTH-1:0] data_q, data_d;
  logic                   pulse_q, pulse_d;
  logic                   sync_err_q, sync_err_d;

  logic                   cnt_zero, cnt_last;
  logic                   gnt_found;
  logic [ID_W-1:0]        gnt_idx;

  assign cnt_zero = (cnt_val == '0);
  assign cnt_last = (cnt_val == CNT_MAX);

  // Round-robin search starting at rr_ptr; first valid index wins.
  always_comb begin
    int idx;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    idx       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr_q) + k) % NUM_REQ;
      if (!gnt_found && req_valid[idx[ID_W-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = idx[ID_W-1:0];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      id_q       <= '0;
      data_q     <= '0;
      pulse_q    <= 1'b0;
      sync_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      id_q       <= id_d;
      data_q     <= data_d;
      pulse_q    <= pulse_d;
      sync_err_q <= sync_err_d;
    end
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    id_d       = id_q;
    data_d     = data_q;
    sync_err_d = sync_err_q;
    pulse_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (gnt_found) begin
          if (cnt_zero) begin
            id_d     = gnt_idx;
            data_d   = req_data[gnt_idx*INPUT_WIDTH +: INPUT_WIDTH];
            rr_ptr_d = (gnt_idx == LAST_IDX) ? '0 : gnt_idx + 1'b1;
            state_d  = SWEEP;
          end else begin
            sync_err_d = 1'b1;
          end
        end
      end
      SWEEP: begin
        pulse_d = !abort && (cnt_val < data_q);
        // Abort on the final count skips DRAIN: the counter is already wrapping.
        if (abort)         state_d = cnt_last ? IDLE : DRAIN;
        else if (cnt_last) state_d = RESP;
      end
      DRAIN: if (cnt_last)  state_d = IDLE;
      RESP:  if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    cnt_en    = 1'b0;
    rsp_valid = 1'b0;
    rsp_id    = '0;
    unique case (state_q)
      IDLE: begin
        if (gnt_found && cnt_zero) req_ready[gnt_idx] = 1'b1;
        // A pending request with a misaligned counter walks it back to zero.
        cnt_en = gnt_found && !cnt_zero;
      end
      SWEEP, DRAIN: cnt_en = 1'b1;
      RESP: begin
        rsp_valid = 1'b1;
        rsp_id    = id_q;
      end
      default: ;
    endcase
  end

  assign busy      = (state_q != IDLE);
  assign pulse_out = pulse_q;
  assign sync_err  = sync_err_q;

endmodule
